// File: rtl/regfile_alu_seq_pkg.sv
// Shared types and constants for the register-file/ALU command sequencer.
//  - opcode and FSM state enums
//  - ALU function-select encodings understood by the datapath
//  - control-word struct, its idle value and a MOV control-word helper
package regfile_alu_seq_pkg;

   localparam int unsigned DW = 64;   // data / immediate width
   localparam int unsigned RW = 5;    // register select width

   localparam logic [RW-1:0] SCRATCH = 5'd30;  // SWAP temporary
   localparam logic [RW-1:0] REG_ZR  = 5'd31;  // zero register, writes discarded

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_ORR  = 4'd3,
      OP_EOR  = 4'd4,
      OP_ADDI = 4'd5,
      OP_SUBI = 4'd6,
      OP_MOVI = 4'd7,
      OP_MOV  = 4'd8,
      OP_SWAP = 4'd9,
      OP_NOP  = 4'd10
   } op_e;

   // FS[4:2] picks the ALU function, FS[1] inverts B, FS[0] inverts A
   localparam logic [4:0] FS_AND = 5'b00000;
   localparam logic [4:0] FS_ORR = 5'b00100;
   localparam logic [4:0] FS_ADD = 5'b01000;
   localparam logic [4:0] FS_SUB = 5'b01010;
   localparam logic [4:0] FS_EOR = 5'b01100;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EXEC,
      ST_SW1,
      ST_SW2,
      ST_SW3
   } state_e;

   typedef struct packed {
      logic          w;
      logic          en_alu;
      logic          en_b;
      logic          k_sel;
      logic          c0;
      logic [RW-1:0] sa;
      logic [RW-1:0] sb;
      logic [RW-1:0] da;
      logic [4:0]    fs;
      logic [DW-1:0] k;
   } cw_t;

   localparam cw_t CW_IDLE = '{w: 1'b0, en_alu: 1'b0, en_b: 1'b0, k_sel: 1'b0, c0: 1'b0,
                               sa: REG_ZR, sb: REG_ZR, da: REG_ZR, fs: 5'd0, k: '0};

   // Register-to-register move through the B bus; writes to the zero register are dropped
   function automatic cw_t mov_cw(input logic [RW-1:0] da, input logic [RW-1:0] src);
      cw_t cw;
      cw       = CW_IDLE;
      cw.en_b  = 1'b1;
      cw.sb    = src;
      cw.da    = da;
      cw.w     = (da != REG_ZR);
      return cw;
   endfunction

endpackage

// File: rtl/regfile_alu_seq_decode.sv
// Combinational command decoder.
//  op/rd/rn/rm/imm in -> cw_c: control word for the op's first write cycle
//  illegal_c: op rejected (undefined opcode or SWAP touching r30/r31)
//  is_swap_c: op is SWAP (multi-cycle)
//  flag_op_c: op may latch Status into the flags register
module regfile_alu_seq_decode
   import regfile_alu_seq_pkg::*;
(
   input  logic [3:0]    op,
   input  logic [RW-1:0] rd,
   input  logic [RW-1:0] rn,
   input  logic [RW-1:0] rm,
   input  logic [DW-1:0] imm,
   output cw_t           cw_c,
   output logic          illegal_c,
   output logic          is_swap_c,
   output logic          flag_op_c
);

   // Opcode table
   always_comb begin
      cw_c      = CW_IDLE;
      illegal_c = 1'b0;
      is_swap_c = 1'b0;
      flag_op_c = 1'b0;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_EOR: begin
            cw_c.en_alu = 1'b1;
            cw_c.sa     = rn;
            cw_c.sb     = rm;
            cw_c.c0     = (op == OP_SUB);
            case (op)
               OP_SUB:  cw_c.fs = FS_SUB;
               OP_AND:  cw_c.fs = FS_AND;
               OP_ORR:  cw_c.fs = FS_ORR;
               OP_EOR:  cw_c.fs = FS_EOR;
               default: cw_c.fs = FS_ADD;
            endcase
            flag_op_c = 1'b1;
         end
         OP_ADDI, OP_SUBI, OP_MOVI: begin
            cw_c.en_alu = 1'b1;
            cw_c.sa     = (op == OP_MOVI) ? REG_ZR : rn;
            cw_c.k      = imm;
            cw_c.k_sel  = 1'b1;
            cw_c.fs     = (op == OP_SUBI) ? FS_SUB : FS_ADD;
            cw_c.c0     = (op == OP_SUBI);
            flag_op_c   = 1'b1;
         end
         OP_MOV:  cw_c = mov_cw(rd, rn);
         OP_SWAP: begin
            is_swap_c = 1'b1;
            if (rn == SCRATCH || rn == REG_ZR || rm == SCRATCH || rm == REG_ZR) begin
               illegal_c = 1'b1;
            end else begin
               cw_c = mov_cw(SCRATCH, rn);
            end
         end
         OP_NOP:  cw_c = CW_IDLE;
         default: illegal_c = 1'b1;
      endcase
      // every write-capable op targets rd, except MOV (already set) and SWAP
      if (cw_c.en_alu) begin
         cw_c.da = rd;
         cw_c.w  = (rd != REG_ZR);
      end
   end

endmodule

// File: rtl/regfile_alu_sequencer.sv
// Command-level controller for the register-file/ALU datapath.
//  cmd_valid/cmd_ready/cmd_*  : one op per handshake, accepted only in IDLE
//  Status                     : datapath {V,C,N,Z} for the current cycle
//  W..K                       : registered datapath control word
//  flags                      : latched {V,C,N,Z}
//  busy/done/cmd_err          : progress, final-cycle pulse, reject pulse
module regfile_alu_sequencer
   import regfile_alu_seq_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [3:0]    cmd_op,
   input  logic [4:0]    cmd_rd,
   input  logic [4:0]    cmd_rn,
   input  logic [4:0]    cmd_rm,
   input  logic [DW-1:0] cmd_imm,
   input  logic          cmd_setf,
   input  logic [3:0]    Status,
   output logic          W,
   output logic          EN_ALU,
   output logic          EN_B,
   output logic          K_SEL,
   output logic          C0,
   output logic [4:0]    SA,
   output logic [4:0]    SB,
   output logic [4:0]    DA,
   output logic [4:0]    FS,
   output logic [DW-1:0] K,
   output logic [3:0]    flags,
   output logic          busy,
   output logic          done,
   output logic          cmd_err
);

   state_e        state_q, state_d;
   cw_t           cw_q, cw_d;
   logic          ready_q, ready_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic          latch_q, latch_d;   // latch Status at the end of this cycle
   logic [3:0]    flags_q, flags_d;
   logic [RW-1:0] rn_q, rn_d;
   logic [RW-1:0] rm_q, rm_d;

   cw_t  dec_cw;
   logic dec_illegal;
   logic dec_swap;
   logic dec_flag_op;

   regfile_alu_seq_decode u_decode (
      .op        (cmd_op),
      .rd        (cmd_rd),
      .rn        (cmd_rn),
      .rm        (cmd_rm),
      .imm       (cmd_imm),
      .cw_c      (dec_cw),
      .illegal_c (dec_illegal),
      .is_swap_c (dec_swap),
      .flag_op_c (dec_flag_op)
   );

   // Next-state and next control word
   always_comb begin
      state_d = state_q;
      cw_d    = CW_IDLE;
      done_d  = 1'b0;
      err_d   = 1'b0;
      latch_d = 1'b0;
      rn_d    = rn_q;
      rm_d    = rm_q;
      flags_d = latch_q ? Status : flags_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid && ready_q) begin
               rn_d = cmd_rn;
               rm_d = cmd_rm;
               cw_d = dec_cw;
               if (dec_swap && !dec_illegal) begin
                  state_d = ST_SW1;
               end else begin
                  state_d = ST_EXEC;
                  done_d  = 1'b1;
                  err_d   = dec_illegal;
                  latch_d = cmd_setf && dec_flag_op;
               end
            end
         end
         ST_SW1: begin
            state_d = ST_SW2;
            cw_d    = mov_cw(rn_q, rm_q);
         end
         ST_SW2: begin
            state_d = ST_SW3;
            cw_d    = mov_cw(rm_q, SCRATCH);
            done_d  = 1'b1;
         end
         default: state_d = ST_IDLE;   // EXEC, SW3
      endcase
      ready_d = (state_d == ST_IDLE);
      busy_d  = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cw_q    <= CW_IDLE;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         latch_q <= 1'b0;
         flags_q <= 4'd0;
         rn_q    <= '0;
         rm_q    <= '0;
      end else begin
         state_q <= state_d;
         cw_q    <= cw_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         latch_q <= latch_d;
         flags_q <= flags_d;
         rn_q    <= rn_d;
         rm_q    <= rm_d;
      end
   end

   assign cmd_ready = ready_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign cmd_err   = err_q;
   assign flags     = flags_q;
   assign W         = cw_q.w;
   assign EN_ALU    = cw_q.en_alu;
   assign EN_B      = cw_q.en_b;
   assign K_SEL     = cw_q.k_sel;
   assign C0        = cw_q.c0;
   assign SA        = cw_q.sa;
   assign SB        = cw_q.sb;
   assign DA        = cw_q.da;
   assign FS        = cw_q.fs;
   assign K         = cw_q.k;

endmodule

// File: tb/tb_regfile_alu_sequencer.sv
// Bench for regfile_alu_sequencer: a small register-file/ALU datapath model reacts to the
// control word; an instruction-level reference keeps the architectural registers and flags.
module tb_regfile_alu_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [3:0]  cmd_op;
   logic [4:0]  cmd_rd, cmd_rn, cmd_rm;
   logic [63:0] cmd_imm;
   logic        cmd_setf;
   logic [3:0]  status;
   logic        W, EN_ALU, EN_B, K_SEL, C0;
   logic [4:0]  SA, SB, DA, FS;
   logic [63:0] K;
   logic [3:0]  flags;
   logic        busy, done, cmd_err;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   regfile_alu_sequencer dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rn(cmd_rn), .cmd_rm(cmd_rm),
      .cmd_imm(cmd_imm), .cmd_setf(cmd_setf), .Status(status),
      .W(W), .EN_ALU(EN_ALU), .EN_B(EN_B), .K_SEL(K_SEL), .C0(C0),
      .SA(SA), .SB(SB), .DA(DA), .FS(FS), .K(K),
      .flags(flags), .busy(busy), .done(done), .cmd_err(cmd_err)
   );

   // ---------------- datapath model ----------------
   logic [63:0] dp_regs [32] = '{default: '0};
   logic [63:0] a_bus, b_bus, a_op, b_op, f_bus, d_bus;
   logic [64:0] sum;

   always_comb begin
      a_bus = (SA == 5'd31) ? 64'd0 : dp_regs[SA];
      b_bus = K_SEL ? K : ((SB == 5'd31) ? 64'd0 : dp_regs[SB]);
      a_op  = FS[0] ? ~a_bus : a_bus;
      b_op  = FS[1] ? ~b_bus : b_bus;
      sum   = {1'b0, a_op} + {1'b0, b_op} + 65'(C0);
      case (FS[4:2])
         3'd0:    f_bus = a_op & b_op;
         3'd1:    f_bus = a_op | b_op;
         3'd2:    f_bus = sum[63:0];
         3'd3:    f_bus = a_op ^ b_op;
         default: f_bus = 64'd0;
      endcase
      status[3] = (FS[4:2] == 3'd2) && (a_op[63] == b_op[63]) && (f_bus[63] != a_op[63]);
      status[2] = (FS[4:2] == 3'd2) && sum[64];
      status[1] = f_bus[63];
      status[0] = (f_bus == 64'd0);
      d_bus = EN_ALU ? f_bus : (EN_B ? b_bus : 64'd0);
   end

   always @(posedge clk) begin
      if (W && DA != 5'd31) dp_regs[DA] <= d_bus;
   end

   // ---------------- reference model ----------------
   logic [63:0] ref_regs [32] = '{default: '0};
   logic [3:0]  ref_flags = 4'd0;

   function automatic logic [63:0] rref(input logic [4:0] r);
      return (r == 5'd31) ? 64'd0 : ref_regs[r];
   endfunction

   function automatic logic [63:0] rdp(input logic [4:0] r);
      return (r == 5'd31) ? 64'd0 : dp_regs[r];
   endfunction

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Issue one command, check timing/writes against the reference, then registers and flags
   task automatic run_op(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rn,
                         input logic [4:0] rm, input logic [63:0] imm, input logic setf);
      logic [63:0] a, b, r;
      logic        c, v, exp_err, wr;
      int          exp_len, exp_w, wcnt, cyc, done_cyc, n;
      logic [4:0]  exp_da [3];
      logic [4:0]  got_da [3];
      logic        got_err;

      a = rref(rn); b = rref(rm); r = 64'd0; c = 1'b0; v = 1'b0;
      exp_err = 1'b0; exp_len = 1; exp_w = 0; wr = 1'b0;
      exp_da = '{default: 5'd0}; got_da = '{default: 5'd0};
      case (op)
         4'd0: begin r = a + b; c = (r < a); v = (a[63] == b[63]) && (r[63] != a[63]); end
         4'd1: begin r = a - b; c = (a >= b); v = (a[63] != b[63]) && (r[63] != a[63]); end
         4'd2: r = a & b;
         4'd3: r = a | b;
         4'd4: r = a ^ b;
         4'd5: begin r = a + imm; c = (r < a); v = (a[63] == imm[63]) && (r[63] != a[63]); end
         4'd6: begin r = a - imm; c = (a >= imm); v = (a[63] != imm[63]) && (r[63] != a[63]); end
         4'd7: r = imm;
         4'd8: r = a;
         4'd9: begin
            if (rn >= 5'd30 || rm >= 5'd30) exp_err = 1'b1;
            else begin
               exp_len = 3; exp_w = 3;
               exp_da[0] = 5'd30; exp_da[1] = rn; exp_da[2] = rm;
               ref_regs[30] = a; ref_regs[rn] = b; ref_regs[rm] = a;
            end
         end
         4'd10: ;
         default: exp_err = 1'b1;
      endcase
      if (op <= 4'd8) begin
         wr = 1'b1;
         if (rd != 5'd31) begin ref_regs[rd] = r; exp_w = 1; exp_da[0] = rd; end
         if (setf && op <= 4'd7) ref_flags = {v, c, r[63], r == 64'd0};
      end

      n = 0;
      while (cmd_ready !== 1'b1 && n < 10) begin @(negedge clk); n++; end
      check_eq("ready", 64'(cmd_ready), 64'd1);
      cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rn = rn; cmd_rm = rm;
      cmd_imm = imm; cmd_setf = setf;
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_op = 4'($urandom); cmd_rd = 5'($urandom); cmd_rn = 5'($urandom);
      check_eq("busy", 64'(busy), 64'd1);
      wcnt = 0; cyc = 0; done_cyc = 0; got_err = 1'b0;
      while (done_cyc == 0 && cyc < 6) begin
         cyc++;
         if (W === 1'b1) begin
            if (wcnt < 3) got_da[wcnt] = DA;
            wcnt++;
         end
         if (done === 1'b1) begin done_cyc = cyc; got_err = cmd_err; end
         else @(negedge clk);
      end
      check_eq("done_lat", 64'(done_cyc), 64'(exp_len));
      check_eq("cmd_err", 64'(got_err), 64'(exp_err));
      check_eq("w_count", 64'(wcnt), 64'(exp_w));
      for (int i = 0; i < exp_w; i++) check_eq("w_da", 64'(got_da[i]), 64'(exp_da[i]));
      @(negedge clk);
      check_eq("done_pulse", 64'(done), 64'd0);
      check_eq("flags", 64'(flags), 64'(ref_flags));
      if (wr) check_eq("reg_rd", rdp(rd), rref(rd));
      check_eq("reg_rn", rdp(rn), rref(rn));
      check_eq("reg_rm", rdp(rm), rref(rm));
   endtask

   logic [63:0] old_a, old_b;

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = 4'd0; cmd_rd = 5'd0; cmd_rn = 5'd0;
      cmd_rm = 5'd0; cmd_imm = 64'd0; cmd_setf = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_ready", 64'(cmd_ready), 64'd1);
      check_eq("rst_w", 64'(W), 64'd0);
      check_eq("rst_sa_da", 64'({SA, SB, DA}), 64'({5'd31, 5'd31, 5'd31}));
      check_eq("rst_ctl", 64'({EN_ALU, EN_B, K_SEL, C0, FS}), 64'd0);
      check_eq("rst_k", K, 64'd0);
      check_eq("rst_stat", 64'({flags, busy, done, cmd_err}), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // directed sequence
      run_op(4'd7, 5'd0, 5'd0, 5'd0, 64'h0000_0000_0000_FFFF, 1'b0);
      run_op(4'd7, 5'd1, 5'd0, 5'd0, 64'h0000_0000_FFFF_0000, 1'b0);
      check_eq("r0_movi", dp_regs[0], 64'h0000_0000_0000_FFFF);
      check_eq("r1_movi", dp_regs[1], 64'h0000_0000_FFFF_0000);
      run_op(4'd6, 5'd4, 5'd1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      check_eq("r4_subi", dp_regs[4], 64'h0000_0000_FFFF_0001);
      check_eq("subi_zn", 64'(flags[1:0]), 64'd0);
      run_op(4'd1, 5'd6, 5'd1, 5'd1, 64'd0, 1'b1);
      check_eq("sub_z", 64'(flags[0]), 64'd1);
      run_op(4'd8, 5'd5, 5'd1, 5'd0, 64'd0, 1'b1);
      check_eq("r5_mov", dp_regs[5], 64'h0000_0000_FFFF_0000);
      check_eq("mov_flags", 64'(flags[0]), 64'd1);
      run_op(4'd9, 5'd0, 5'd0, 5'd1, 64'd0, 1'b0);
      check_eq("swap_r0", dp_regs[0], 64'h0000_0000_FFFF_0000);
      check_eq("swap_r1", dp_regs[1], 64'h0000_0000_0000_FFFF);
      run_op(4'd9, 5'd0, 5'd30, 5'd1, 64'd0, 1'b0);
      run_op(4'd9, 5'd0, 5'd2, 5'd31, 64'd0, 1'b0);
      run_op(4'd9, 5'd0, 5'd3, 5'd3, 64'd0, 1'b0);
      run_op(4'd12, 5'd7, 5'd0, 5'd1, 64'd0, 1'b1);
      run_op(4'd0, 5'd31, 5'd0, 5'd1, 64'd0, 1'b1);
      run_op(4'd10, 5'd8, 5'd0, 5'd1, 64'd0, 1'b1);

      // randomized commands
      for (int t = 0; t < 300; t++) begin
         logic [3:0]  op;
         logic [63:0] imm;
         op = ($urandom_range(0, 4) == 0) ? 4'd9 : 4'($urandom_range(0, 15));
         case ($urandom_range(0, 3))
            0:       imm = 64'd0;
            1:       imm = 64'hFFFF_FFFF_FFFF_FFFF;
            2:       imm = 64'h8000_0000_0000_0000 ^ 64'($urandom_range(0, 3));
            default: imm = {$urandom, $urandom};
         endcase
         run_op(op, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                5'($urandom_range(0, 31)), imm, 1'($urandom));
      end

      // reset in the middle of a SWAP
      run_op(4'd7, 5'd2, 5'd0, 5'd0, 64'h1234_5678_9ABC_DEF0, 1'b0);
      run_op(4'd7, 5'd3, 5'd0, 5'd0, 64'h0F0F_0000_AAAA_5555, 1'b0);
      run_op(4'd1, 5'd7, 5'd2, 5'd2, 64'd0, 1'b1);
      check_eq("pre_rst_flags", 64'(flags != 4'd0), 64'd1);
      old_a = ref_regs[2]; old_b = ref_regs[3];
      cmd_valid = 1'b1; cmd_op = 4'd9; cmd_rn = 5'd2; cmd_rm = 5'd3; cmd_setf = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      check_eq("sw2_da", 64'({W, DA}), 64'({1'b1, 5'd2}));
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_eq("mid_rst_ready", 64'(cmd_ready), 64'd1);
      check_eq("mid_rst_w", 64'(W), 64'd0);
      check_eq("mid_rst_flags", 64'(flags), 64'd0);
      check_eq("mid_rst_busy", 64'({busy, done, cmd_err}), 64'd0);
      check_eq("mid_rst_r30", dp_regs[30], old_a);
      ref_regs[30] = old_a; ref_regs[2] = old_b; ref_flags = 4'd0;
      @(negedge clk);
      run_op(4'd0, 5'd9, 5'd2, 5'd3, 64'd0, 1'b1);

      for (int i = 0; i < 32; i++) check_eq("final_reg", rdp(5'(i)), rref(5'(i)));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
